// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS CPU: state codes, opcodes,
// datapath mux encodings and the control word used by the main control unit.
package mc_cpu_pkg;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the main control unit and the datapath it sequences.
interface mc_control_fsm_if #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
);
  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            PCWre;
  logic [1:0]      PCSource;
  logic            IorD;
  logic            MemRead;
  logic            MemWrite;
  logic            IRWrite;
  logic            RegDst;
  logic            MemtoReg;
  logic            RegWrite;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ALUOp;
  logic            illegal_op;
  logic [ST_W-1:0] state;

  modport master (
    input  opcode, zero,
    output PCWre, PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst,
           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op, state
  );

  modport slave (
    output opcode, zero,
    input  PCWre, PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst,
           MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op, state
  );
endinterface

// File: rtl/mc_control_decode.sv
// Purely combinational Moore decode: current state to datapath control word.
module mc_control_decode
  import mc_cpu_pkg::*;
(
  input  state_t st,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (st)
      S_IF: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_ID: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control unit of the multi-cycle MIPS CPU: state register, opcode latch,
// next-state dispatch and PC write-enable gating.
module mc_control_fsm
  import mc_cpu_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input logic              clk,
  input logic              rst,
  mc_control_fsm_if.master bus
);

  state_t          state_q, state_d, dec_state;
  logic [OP_W-1:0] op_q;
  logic            illegal;
  logic            branch_taken;
  ctrl_t           ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= bus.opcode;
    end
  end

  always_comb begin
    state_d = S_IF;
    illegal = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (bus.opcode)
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_RTYPE:       state_d = S_R_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI:        state_d = S_I_EXEC;
          default: begin
            state_d = S_IF;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_IF;
    endcase
  end

  // In reset the selects show their IF values while every enable is masked off.
  assign dec_state = rst ? S_IF : state_q;

  mc_control_decode u_decode (
    .st   (dec_state),
    .ctrl (ctrl)
  );

  assign branch_taken = (op_q == OP_BNE) ? ~bus.zero : bus.zero;

  always_comb begin
    bus.PCWre      = ~rst & (ctrl.pc_write | (ctrl.pc_write_cond & branch_taken));
    bus.PCSource   = ctrl.pc_source;
    bus.IorD       = ctrl.iord;
    bus.MemRead    = ~rst & ctrl.mem_read;
    bus.MemWrite   = ~rst & ctrl.mem_write;
    bus.IRWrite    = ~rst & ctrl.ir_write;
    bus.RegDst     = ctrl.reg_dst;
    bus.MemtoReg   = ctrl.mem_to_reg;
    bus.RegWrite   = ~rst & ctrl.reg_write;
    bus.ALUSrcA    = ctrl.alu_src_a;
    bus.ALUSrcB    = ctrl.alu_src_b;
    bus.ALUOp      = ctrl.alu_op;
    bus.illegal_op = ~rst & illegal;
    bus.state      = ST_W'(state_q);
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm against an instruction-level model.
module tb_mc_control_fsm;

  typedef int trace_t[$];

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mc_control_fsm_if #(.OP_W(6), .ST_W(4)) bus ();

  mc_control_fsm #(.OP_W(6), .ST_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // instruction class: 0 lw, 1 sw, 2 R, 3 addi, 4 beq, 5 bne, 6 j, 7 illegal
  function automatic int op_class(input logic [5:0] op);
    case (op)
      6'b100011: return 0;
      6'b101011: return 1;
      6'b000000: return 2;
      6'b001000: return 3;
      6'b000100: return 4;
      6'b000101: return 5;
      6'b000010: return 6;
      default:   return 7;
    endcase
  endfunction

  function automatic trace_t exp_trace(input int c);
    case (c)
      0:       return '{0, 1, 2, 3, 4};
      1:       return '{0, 1, 2, 5};
      2:       return '{0, 1, 6, 7};
      3:       return '{0, 1, 10, 11};
      4, 5:    return '{0, 1, 8};
      6:       return '{0, 1, 9};
      default: return '{0, 1};
    endcase
  endfunction

  // {PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp}
  function automatic logic [13:0] exp_vec(input int st);
    logic [1:0] pcsrc, srcb, aluop;
    logic iord, mrd, mwr, irw, rdst, m2r, rw, srca;
    {pcsrc, srcb, aluop} = '0;
    {iord, mrd, mwr, irw, rdst, m2r, rw, srca} = '0;
    case (st)
      0:  begin mrd = 1; irw = 1; srcb = 2'b01; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; end
      9:  pcsrc = 2'b10;
      10: begin srca = 1; srcb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pcsrc, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aluop};
  endfunction

  function automatic logic [13:0] act_vec();
    return {bus.PCSource, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegDst,
            bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp};
  endfunction

  // Runs one instruction starting in IF; returns just after the edge that ends it.
  task automatic run_instr(input logic [5:0] op, input logic z);
    int     c;
    trace_t tr;
    logic   exp_pcwre, exp_ill;
    c  = op_class(op);
    tr = exp_trace(c);
    foreach (tr[i]) begin
      bus.opcode = (i <= 1) ? op : 6'($urandom);
      bus.zero   = (tr[i] == 8) ? z : 1'($urandom);
      @(negedge clk);
      exp_pcwre = (tr[i] == 0) || (tr[i] == 9) || (tr[i] == 8 && (c == 4 ? z : !z));
      exp_ill   = (c == 7) && (tr[i] == 1);
      checks++;
      if (bus.state !== 4'(tr[i])) begin
        errors++;
        $display("FAIL state op=%b step %0d: got %0d expected %0d", op, i, bus.state, tr[i]);
      end
      checks++;
      if (bus.PCWre !== exp_pcwre) begin
        errors++;
        $display("FAIL pcwre op=%b z=%b step %0d: got %b expected %b", op, z, i, bus.PCWre, exp_pcwre);
      end
      checks++;
      if (act_vec() !== exp_vec(tr[i])) begin
        errors++;
        $display("FAIL ctrl op=%b step %0d: got %b expected %b", op, i, act_vec(), exp_vec(tr[i]));
      end
      checks++;
      if (bus.illegal_op !== exp_ill) begin
        errors++;
        $display("FAIL illegal_op op=%b step %0d: got %b expected %b", op, i, bus.illegal_op, exp_ill);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_fetch_after_reset();
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.PCWre !== 1'b1 || bus.MemRead !== 1'b1 || bus.IRWrite !== 1'b1) begin
      errors++;
      $display("FAIL release: got state=%0d PCWre=%b MemRead=%b IRWrite=%b expected 0 1 1 1",
               bus.state, bus.PCWre, bus.MemRead, bus.IRWrite);
    end
  endtask

  task automatic test_reset();
    int k;
    k = $urandom_range(0, 4);
    bus.opcode = 6'b100011;
    for (int i = 0; i < k; i++) begin
      bus.zero = 1'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.opcode = 6'($urandom);
      bus.zero   = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({bus.PCWre, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.illegal_op} !== 6'b0) begin
        errors++;
        $display("FAIL reset_enables cycle %0d: got %b expected 000000", i,
                 {bus.PCWre, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.illegal_op});
      end
      @(posedge clk); #1;
      checks++;
      if (bus.state !== 4'd0) begin
        errors++;
        $display("FAIL reset_state cycle %0d: got %0d expected 0", i, bus.state);
      end
    end
    rst = 1'b0;
    check_fetch_after_reset();
  endtask

  task automatic test_lw();
    run_instr(6'b100011, 1'b0);
    run_instr(6'b101011, 1'b1);
  endtask

  task automatic test_branch();
    run_instr(6'b000100, 1'b1);
    run_instr(6'b000100, 1'b0);
    run_instr(6'b000101, 1'b1);
    run_instr(6'b000101, 1'b0);
  endtask

  task automatic test_jump_rtype();
    run_instr(6'b000010, 1'b0);
    run_instr(6'b000000, 1'b0);
    run_instr(6'b001000, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr(6'b111111, 1'b0);
    run_instr(6'b000001, 1'b1);
  endtask

  task automatic test_reset_mid_write();
    bus.opcode = 6'b101011;
    bus.zero   = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.state !== 4'd5 || bus.MemWrite !== 1'b0 || bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL abort_write: got state=%0d MemWrite=%b RegWrite=%b expected 5 0 0",
               bus.state, bus.MemWrite, bus.RegWrite);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    check_fetch_after_reset();
  endtask

  task automatic test_back_to_back();
    logic [5:0] legal [7];
    logic [5:0] op;
    legal = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000101, 6'b000010};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = legal[$urandom_range(0, 6)];
      run_instr(op, 1'($urandom));
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.opcode = '0;
    bus.zero   = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_lw();
    test_branch();
    test_jump_rtype();
    test_illegal();
    test_reset_mid_write();
    test_back_to_back();
    test_reset();
    run_instr(6'b100011, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
